serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) built around a single full_subtractor.
// Define SERIAL_SUB_SIGNED_EN to add the signed overflow output.

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    output logic             overflow
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] op_a_reg, op_b_reg, res_reg, diff_reg;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt_reg;
    logic             bff_reg, borrow_reg;
    logic             diff_bit, bout_bit;
    logic             accept, last_bit;

    full_subtractor u_fs (
        .a    (op_a_reg[0]),
        .b    (op_b_reg[0]),
        .bin  (bff_reg),
        .diff (diff_bit),
        .bout (bout_bit)
    );

    generate
        if (WIDTH == 1) begin : g_res1
            assign res_next = diff_bit;
        end else begin : g_resn
            assign res_next = {diff_bit, res_reg[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = start && (state_reg == IDLE || state_reg == DONE);
    assign last_bit = (state_reg == SHIFT) && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = start ? SHIFT : IDLE;
            SHIFT:   state_next = last_bit ? DONE : SHIFT;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == SHIFT);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            res_reg    <= '0;
            bff_reg    <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else if (accept) begin
            op_a_reg <= a;
            op_b_reg <= b;
            bff_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else if (state_reg == SHIFT) begin
            op_a_reg <= op_a_reg >> 1;
            op_b_reg <= op_b_reg >> 1;
            res_reg  <= res_next;
            bff_reg  <= bout_bit;
            cnt_reg  <= cnt_reg + CW'(1);
            if (last_bit) begin
                diff_reg   <= res_next;
                borrow_reg <= bout_bit;
            end
        end
    end

    assign diff   = diff_reg;
    assign borrow = borrow_reg;

`ifdef SERIAL_SUB_SIGNED_EN
    logic overflow_reg;

    // On the last bit the operand LSBs are the original MSBs.
    always_ff @(posedge clk) begin
        if (rst)
            overflow_reg <= 1'b0;
        else if (last_bit)
            overflow_reg <= (op_a_reg[0] != op_b_reg[0]) && (diff_bit != op_a_reg[0]);
    end

    assign overflow = overflow_reg;
`endif

endmodule
